// File: rtl/score_accumulator.sv
// score_accumulator: debounced 1/2/3-point buttons drive an external adder, and the saturated result lands in score (optional undo under SCORE_UNDO_EN).
// Latency: commit 2 cycles after the debounced rise. No backpressure: busy holds until every button is released.
module score_accumulator #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_SCORE       = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic       btn_p3,
    input  logic       mode_sub,
    input  logic       clear,
`ifdef SCORE_UNDO_EN
    input  logic       btn_undo,
`endif
    output logic [6:0] add_a,
    output logic [1:0] add_b,
    output logic       add_sub,
    input  logic [6:0] add_s,
    input  logic       add_cout,
    output logic [6:0] score,
    output logic       busy,
    output logic       sat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [6:0] MAX7 = 7'(MAX_SCORE);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

`ifdef SCORE_UNDO_EN
    localparam int NB = 4;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_undo, btn_p3, btn_p2, btn_p1};
    logic [6:0] prev_score;
    logic       clr_q;
`else
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_p3, btn_p2, btn_p1};
`endif

    logic [NB-1:0] btn_s1;
    logic [NB-1:0] btn_s2;
    logic [NB-1:0] deb;
    logic [CW-1:0] cnt [NB];
    logic          clr_s1;
    logic          clr_s2;
    logic [1:0]    state;
    logic [1:0]    code;
    logic          mode_l;
    logic [1:0]    press_code;

    always_comb begin
        deb = '0;
        for (int i = 0; i < NB; i++) begin
            deb[i] = (cnt[i] == DB_MAX);
        end
    end

    // Point-button priority: 3 beats 2 beats 1.
    always_comb begin
        press_code = 2'b00;
        if (deb[2])      press_code = 2'b11;
        else if (deb[1]) press_code = 2'b10;
        else if (deb[0]) press_code = 2'b01;
    end

    assign add_a   = score;
    assign add_b   = (state == CALC) ? code : 2'b00;
    assign add_sub = (state == CALC) ? mode_l : 1'b0;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
            state  <= IDLE;
            code   <= 2'b00;
            mode_l <= 1'b0;
            score  <= 7'd0;
            sat    <= 1'b0;
`ifdef SCORE_UNDO_EN
            prev_score <= 7'd0;
            clr_q      <= 1'b0;
`endif
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            clr_s1 <= clear;
            clr_s2 <= clr_s1;
            for (int i = 0; i < NB; i++) begin
                if (!btn_s2[i])
                    cnt[i] <= '0;
                else if (cnt[i] != DB_MAX)
                    cnt[i] <= cnt[i] + CW'(1);
            end
            sat <= 1'b0;
`ifdef SCORE_UNDO_EN
            clr_q <= clr_s2;
`endif

            if (clr_s2) begin
                score <= 7'd0;
`ifdef SCORE_UNDO_EN
                // Only the first cycle of a held clear snapshots the live score.
                if (!clr_q)
                    prev_score <= score;
`endif
                if (state == CALC)
                    state <= RELEASE;
            end else begin
                case (state)
                    IDLE: begin
                        if (press_code != 2'b00) begin
                            code   <= press_code;
                            mode_l <= mode_sub;
                            state  <= CALC;
                        end
`ifdef SCORE_UNDO_EN
                        else if (deb[3]) begin
                            score <= prev_score;
                            state <= RELEASE;
                        end
`endif
                    end
                    CALC: begin
`ifdef SCORE_UNDO_EN
                        prev_score <= score;
`endif
                        if (!mode_l) begin
                            if (add_cout || (add_s > MAX7)) begin
                                score <= MAX7;
                                sat   <= 1'b1;
                            end else begin
                                score <= add_s;
                            end
                        end else begin
                            // Subtract: carry-out low means the result borrowed below zero.
                            if (!add_cout) begin
                                score <= 7'd0;
                                sat   <= 1'b1;
                            end else begin
                                score <= add_s;
                            end
                        end
                        state <= RELEASE;
                    end
                    RELEASE: begin
                        if (deb == '0)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
